channel_voice_pwm: RTL

Per-channel output stage that consumes a channel note sequencer's outputs: PWM top (`top`/`top_valid`), 32-bit phase increment and 9-bit envelope. It runs a phase accumulator that advances once per PWM period and derives a square-wave level. The level is scaled by the envelope and saturated. The result is emitted as a glitch-free PWM bit whose period is set by the sequencer's top value. It sits between a channel sequencer and the board-level mixer/pin driver.

---
 rtl/channel_voice_pwm.sv | 110 +++++++++++
 1 files changed

// File: rtl/channel_voice_pwm.sv
// ---------------------------------------------------------------------------
// channel_voice_pwm
//
// Purpose: per-channel voice output stage. A phase accumulator advances once
// per PWM period by the sequencer's phase increment. Its MSB gives a square
// wave level. That level is scaled by the envelope, shifted down and saturated
// to 8 bits, and used as the PWM compare value. The result is a glitch-free
// PWM bit whose period (top+1 clocks) is set by the sequencer.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_top          requested PWM top (period = top+1 clocks, 0 treated as 1)
//   i_top_valid    qualifies i_top, sampled every cycle
//   i_phase_delta  per-period phase increment, 0 = rest
//   i_envelope     amplitude multiplier
//   o_pwm          registered PWM output
//   o_sample       compare value in force this period
//   o_period_stb   one-cycle pulse on the last cycle of each PWM period
// ---------------------------------------------------------------------------
module channel_voice_pwm #(
  parameter int PHASE_WIDTH = 32,
  parameter int ENV_WIDTH   = 9,
  parameter int ENV_SHIFT   = 4,
  parameter int RESET_TOP   = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_top,
  input  logic                   i_top_valid,
  input  logic [PHASE_WIDTH-1:0] i_phase_delta,
  input  logic [ENV_WIDTH-1:0]   i_envelope,
  output logic                   o_pwm,
  output logic [7:0]             o_sample,
  output logic                   o_period_stb
);

  localparam int PROD_WIDTH = 8 + ENV_WIDTH;
  // A top of 0 would give a one-clock period with no room for a low phase,
  // so it is promoted to 1 everywhere, including the reset value.
  localparam logic [7:0] RESET_TOP_EFF = (RESET_TOP == 0) ? 8'd1 : 8'(RESET_TOP);

  logic [7:0]             r_cnt;
  logic [7:0]             r_top_active;
  logic [7:0]             r_top_pending;
  logic [PHASE_WIDTH-1:0] r_phase;
  logic [7:0]             r_compare;
  logic                   r_pwm;

  logic                   w_pe;
  logic [7:0]             w_top_eff;
  logic [7:0]             w_top_next;
  logic [7:0]             w_level;
  logic [PROD_WIDTH-1:0]  w_prod;
  logic [PROD_WIDTH-1:0]  w_scaled;
  logic [7:0]             w_sample;

  assign w_pe       = (r_cnt == r_top_active);
  assign w_top_eff  = (i_top == 8'd0) ? 8'd1 : i_top;
  // A valid top arriving in the period-end cycle is used directly so that it
  // governs the very next period.
  assign w_top_next = i_top_valid ? w_top_eff : r_top_pending;

  // Sample is derived from the phase before this period's increment, so the
  // level lags the phase update by one period.
  assign w_level  = r_phase[PHASE_WIDTH-1] ? 8'hFF : 8'h00;
  assign w_prod   = PROD_WIDTH'(w_level) * PROD_WIDTH'(i_envelope);
  assign w_scaled = w_prod >> ENV_SHIFT;

  always_comb begin
    w_sample = w_scaled[7:0];
    if (|w_scaled[PROD_WIDTH-1:8]) begin
      w_sample = 8'hFF;
    end
    if (i_phase_delta == '0) begin
      w_sample = 8'h00;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= 8'd0;
      r_top_active  <= RESET_TOP_EFF;
      r_top_pending <= RESET_TOP_EFF;
      r_phase       <= '0;
      r_compare     <= 8'd0;
      r_pwm         <= 1'b0;
    end else begin
      if (i_top_valid) begin
        r_top_pending <= w_top_eff;
      end
      r_pwm <= (r_cnt < r_compare);
      // Compare and top only change at the end of a period, which keeps
      // every PWM pulse whole.
      if (w_pe) begin
        r_cnt        <= 8'd0;
        r_top_active <= w_top_next;
        r_phase      <= r_phase + i_phase_delta;
        r_compare    <= w_sample;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_pwm        = r_pwm;
  assign o_sample     = r_compare;
  assign o_period_stb = w_pe;

endmodule
